// File: rtl/axi_read_pkg.sv
// Shared encodings, FSM state codes and the clogb2 helper for the AXI4 burst read master.
package axi_read_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Ceiling log2; clogb2(1) = 0.
  function automatic int clogb2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res = res + 1;
    return res;
  endfunction

endpackage

// File: rtl/axi_rd_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is always visible on o_rd_data.
module axi_rd_fifo
  import axi_read_pkg::*;
#(
  parameter int WIDTH = 65,
  parameter int DEPTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_wr_en,
  input  logic [WIDTH-1:0]        i_wr_data,
  input  logic                    i_rd_en,
  output logic [WIDTH-1:0]        o_rd_data,
  output logic [clogb2(DEPTH):0]  o_count,
  output logic                    o_empty
);

  localparam int AW = clogb2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_wr_en, i_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);

endmodule

// File: rtl/axi_read.sv
// AXI4 INCR burst read master: fetches burst_num bursts of AR_LEN beats and streams them out
// through a FWFT FIFO; each AR is only issued once the FIFO can absorb the whole burst.
module axi_read
  import axi_read_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int AR_LEN     = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_areset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           burst_num,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] M_RD_tdata,
  output logic                  M_RD_tvalid,
  output logic                  M_RD_tlast,
  input  logic                  M_RD_tready,
  output logic                  m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic                  m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int STRIDE     = AR_LEN * BYTES;
  localparam int STRIDE_LSB = clogb2(STRIDE);
  localparam int CNT_W      = clogb2(FIFO_DEPTH) + 1;

  // Aligning the base to the burst stride keeps every burst inside one 4 KB page.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK  = {ADDR_WIDTH{1'b1}} << STRIDE_LSB;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(STRIDE);
  localparam logic [7:0]            ARLEN_VAL  = 8'(AR_LEN - 1);
  localparam logic [2:0]            ARSIZE_VAL = 3'(clogb2(BYTES));

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_bursts;
  logic [7:0]            r_beat;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  r_arvalid;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;
  logic [2:0]            r_arsize;
  logic [1:0]            r_arburst;
  logic [3:0]            r_arcache;
  logic                  r_rready;

  logic [CNT_W-1:0]      w_count;
  logic                  w_empty;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic                  w_space_ok;
  logic [DATA_WIDTH:0]   w_rd_data;
  logic                  w_unused;

  assign w_space_ok = (FIFO_DEPTH - int'(w_count)) >= AR_LEN;
  assign w_wr_en    = r_rready && m_axi_rvalid;
  assign w_rd_en    = M_RD_tready && !w_empty;
  assign w_unused   = m_axi_rid;

  axi_rd_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (m_axi_aclk),
    .i_rst     (m_axi_areset),
    .i_wr_en   (w_wr_en),
    .i_wr_data ({m_axi_rlast, m_axi_rdata}),
    .i_rd_en   (w_rd_en),
    .o_rd_data (w_rd_data),
    .o_count   (w_count),
    .o_empty   (w_empty)
  );

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_bursts  <= '0;
      r_beat    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_arcache <= '0;
      r_rready  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // busy is still high in the done cycle, so a start there is ignored
          r_busy <= 1'b0;
          if (start && !r_busy) begin
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
            r_arlen   <= ARLEN_VAL;
            r_arsize  <= ARSIZE_VAL;
            r_arburst <= AXI_BURST_INCR;
            r_arcache <= AXI_CACHE_BUF;
            if (burst_num != 16'd0) begin
              r_addr   <= base_addr & ADDR_MASK;
              r_bursts <= burst_num;
              r_state  <= ST_ADDR;
            end else begin
              r_state  <= ST_DONE;
            end
          end
        end
        ST_ADDR: begin
          if (!r_arvalid) begin
            if (w_space_ok) begin
              r_arvalid <= 1'b1;
              r_araddr  <= r_addr;
            end
          end else if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_beat    <= '0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (m_axi_rvalid) begin
            r_beat <= r_beat + 8'd1;
            if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast && (r_beat != ARLEN_VAL)))
              r_err <= 1'b1;
            if (m_axi_rlast) begin
              r_rready <= 1'b0;
              if (r_bursts != 16'd1) begin
                r_bursts <= r_bursts - 16'd1;
                r_addr   <= r_addr + ADDR_STEP;
                r_state  <= ST_ADDR;
              end else begin
                r_bursts <= '0;
                r_state  <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          if (w_empty) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign M_RD_tvalid   = !w_empty;
  assign M_RD_tdata    = w_empty ? '0 : w_rd_data[DATA_WIDTH-1:0];
  assign M_RD_tlast    = !w_empty && w_rd_data[DATA_WIDTH];
  assign m_axi_arid    = 1'b0;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = r_arlen;
  assign m_axi_arsize  = r_arsize;
  assign m_axi_arburst = r_arburst;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = r_arcache;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi_read.sv
// Directed bench for axi_read: a behavioural AXI read slave, a stream monitor and one task per scenario.
module tb_axi_read;

  logic        clk, rst, start, tready;
  logic [31:0] base_addr;
  logic [15:0] burst_num;
  logic        busy, done, err, tvalid, tlast;
  logic [63:0] tdata;
  logic        arid, arlock, arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, rresp;
  logic [3:0]  arcache, arqos;
  logic        rid, rlast, rvalid, rready;
  logic [63:0] rdata;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic done_busy = 1'b0;
  bit ar_unstable = 1'b0;
  int slave_len = 16;
  int slave_err_beat = -1;
  int ar_delay = 0;

  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  logic [2:0]  ar_size_q[$];
  logic [14:0] ar_misc_q[$];
  logic [64:0] beat_q[$];

  axi_read dut (
    .m_axi_aclk(clk), .m_axi_areset(rst), .start(start), .base_addr(base_addr), .burst_num(burst_num),
    .busy(busy), .done(done), .err(err),
    .M_RD_tdata(tdata), .M_RD_tvalid(tvalid), .M_RD_tlast(tlast), .M_RD_tready(tready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache), .m_axi_arprot(arprot),
    .m_axi_arqos(arqos), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Read slave: rdata = {burst address, beat index}; one beat per cycle once the AR is taken.
  initial begin
    int s_beat;
    int s_wait;
    bit s_active;
    logic [31:0] s_addr;
    s_beat = 0; s_wait = 0; s_active = 1'b0; s_addr = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = 1'b0;
    forever begin
      @(negedge clk);
      arready = 1'b0;
      if (rst) begin
        s_active = 1'b0; s_wait = 0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      end else if (s_active) begin
        if (s_beat < slave_len) begin
          rvalid = 1'b1;
          rdata  = {s_addr, 32'(s_beat)};
          rresp  = (s_beat == slave_err_beat) ? 2'b10 : 2'b00;
          rlast  = (s_beat == slave_len - 1);
          rid    = 1'b1;
          s_beat++;
        end else begin
          rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; s_active = 1'b0;
        end
      end else if (arvalid) begin
        if (s_wait == 0) s_addr = araddr;
        else if (araddr !== s_addr) ar_unstable = 1'b1;
        if (s_wait < ar_delay) s_wait++;
        else begin
          arready = 1'b1;
          ar_addr_q.push_back(araddr);
          ar_len_q.push_back(arlen);
          ar_size_q.push_back(arsize);
          ar_misc_q.push_back({arburst, arcache, arprot, arqos, arid, arlock});
          s_wait = 0; s_active = 1'b1; s_beat = 0;
        end
      end
    end
  end

  // Stream and done monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && tvalid && tready) beat_q.push_back({tlast, tdata});
      if (!rst && done) begin
        done_cnt++;
        done_busy = busy;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    ar_addr_q.delete(); ar_len_q.delete(); ar_size_q.delete(); ar_misc_q.delete(); beat_q.delete();
  endtask

  task automatic do_start(input logic [31:0] base, input logic [15:0] num);
    @(negedge clk);
    start = 1'b1; base_addr = base; burst_num = num;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int c0;
    c0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (done_cnt != c0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; burst_num = '0; tready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({arvalid, rready, tvalid, tlast, busy, done, err} !== 7'b0) begin errors++;
      $display("FAIL reset_ctrl got %b exp 0000000", {arvalid, rready, tvalid, tlast, busy, done, err}); end
    checks++; if (araddr !== 32'h0) begin errors++; $display("FAIL reset_araddr got %h exp 0", araddr); end
    checks++; if ({arlen, arsize, arburst, arcache} !== 17'h0) begin errors++;
      $display("FAIL reset_ar_attr got %h exp 0", {arlen, arsize, arburst, arcache}); end
    checks++; if (tdata !== 64'h0) begin errors++; $display("FAIL reset_tdata got %h exp 0", tdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    tready = 1'b1;
    do_start(32'h1000_0000, 16'd1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_after_start got %b exp 1", busy); end
    wait_done(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done_timeout got 0 exp 1"); end
    checks++; if (ar_addr_q.size() != 1) begin errors++; $display("FAIL single_ar_count got %0d exp 1", ar_addr_q.size()); end
    if (ar_addr_q.size() > 0) begin
      checks++; if (ar_addr_q[0] !== 32'h1000_0000) begin errors++; $display("FAIL single_araddr got %h exp 10000000", ar_addr_q[0]); end
      checks++; if (ar_len_q[0] !== 8'd15) begin errors++; $display("FAIL single_arlen got %0d exp 15", ar_len_q[0]); end
      checks++; if (ar_size_q[0] !== 3'd3) begin errors++; $display("FAIL single_arsize got %0d exp 3", ar_size_q[0]); end
      checks++; if (ar_misc_q[0] !== {2'b01, 4'b0011, 3'b000, 4'b0000, 1'b0, 1'b0}) begin errors++;
        $display("FAIL single_ar_misc got %h exp %h", ar_misc_q[0], {2'b01, 4'b0011, 3'b000, 4'b0000, 1'b0, 1'b0}); end
    end
    checks++; if (beat_q.size() != 16) begin errors++; $display("FAIL single_beat_count got %0d exp 16", beat_q.size()); end
    for (int i = 0; i < beat_q.size() && i < 16; i++) begin
      checks++; if (beat_q[i] !== {(i == 15), 32'h1000_0000, 32'(i)}) begin errors++;
        $display("FAIL single_beat%0d got %h exp %h", i, beat_q[i], {(i == 15), 32'h1000_0000, 32'(i)}); end
    end
    checks++; if (done_busy !== 1'b1) begin errors++; $display("FAIL single_busy_at_done got %b exp 1", done_busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", err); end
    @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL single_after_done busy,done got %b exp 00", {busy, done}); end
  endtask

  task automatic test_multi();
    bit ok;
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'h1000_0000; exp_addr[1] = 32'h1000_0080; exp_addr[2] = 32'h1000_0100;
    clear_logs();
    ar_unstable = 1'b0;
    ar_delay = 3;
    tready = 1'b1;
    do_start(32'h1000_0040, 16'd3);
    wait_done(800, ok);
    ar_delay = 0;
    checks++; if (!ok) begin errors++; $display("FAIL multi_done_timeout got 0 exp 1"); end
    checks++; if (ar_addr_q.size() != 3) begin errors++; $display("FAIL multi_ar_count got %0d exp 3", ar_addr_q.size()); end
    for (int b = 0; b < ar_addr_q.size() && b < 3; b++) begin
      checks++; if (ar_addr_q[b] !== exp_addr[b]) begin errors++;
        $display("FAIL multi_araddr%0d got %h exp %h", b, ar_addr_q[b], exp_addr[b]); end
    end
    checks++; if (ar_unstable !== 1'b0) begin errors++; $display("FAIL multi_araddr_stable got %b exp 0", ar_unstable); end
    checks++; if (beat_q.size() != 48) begin errors++; $display("FAIL multi_beat_count got %0d exp 48", beat_q.size()); end
    for (int k = 0; k < beat_q.size() && k < 48; k++) begin
      checks++; if (beat_q[k] !== {((k % 16) == 15), exp_addr[k / 16], 32'(k % 16)}) begin errors++;
        $display("FAIL multi_beat%0d got %h exp %h", k, beat_q[k], {((k % 16) == 15), exp_addr[k / 16], 32'(k % 16)}); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL multi_err got %b exp 0", err); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'h2000_0000; exp_addr[1] = 32'h2000_0080; exp_addr[2] = 32'h2000_0100;
    clear_logs();
    tready = 1'b0;
    do_start(32'h2000_0000, 16'd3);
    for (int i = 0; i < 400 && ar_addr_q.size() < 2; i++) @(negedge clk);
    repeat (40) @(negedge clk);
    // FIFO holds 32 entries here
    checks++; if (ar_addr_q.size() != 2) begin errors++; $display("FAIL bp_ar_withheld_full got %0d exp 2", ar_addr_q.size()); end
    checks++; if ({arvalid, tvalid} !== 2'b01) begin errors++; $display("FAIL bp_full_arvalid,tvalid got %b exp 01", {arvalid, tvalid}); end
    checks++; if ({tlast, tdata} !== {1'b0, 32'h2000_0000, 32'd0}) begin errors++;
      $display("FAIL bp_head_held got %h exp %h", {tlast, tdata}, {1'b0, 32'h2000_0000, 32'd0}); end
    tready = 1'b1;
    repeat (15) @(negedge clk);
    tready = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (beat_q.size() != 15) begin errors++; $display("FAIL bp_popped got %0d exp 15", beat_q.size()); end
    checks++; if (ar_addr_q.size() != 2) begin errors++; $display("FAIL bp_ar_withheld_17 got %0d exp 2", ar_addr_q.size()); end
    checks++; if ({tlast, tdata} !== {1'b1, 32'h2000_0000, 32'd15}) begin errors++;
      $display("FAIL bp_tlast_held got %h exp %h", {tlast, tdata}, {1'b1, 32'h2000_0000, 32'd15}); end
    tready = 1'b1;
    @(negedge clk);
    tready = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (ar_addr_q.size() != 3) begin errors++; $display("FAIL bp_ar_released_16 got %0d exp 3", ar_addr_q.size()); end
    tready = 1'b1;
    wait_done(800, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout got 0 exp 1"); end
    checks++; if (beat_q.size() != 48) begin errors++; $display("FAIL bp_beat_count got %0d exp 48", beat_q.size()); end
    for (int k = 0; k < beat_q.size() && k < 48; k++) begin
      checks++; if (beat_q[k] !== {((k % 16) == 15), exp_addr[k / 16], 32'(k % 16)}) begin errors++;
        $display("FAIL bp_beat%0d got %h exp %h", k, beat_q[k], {((k % 16) == 15), exp_addr[k / 16], 32'(k % 16)}); end
    end
    for (int b = 0; b < ar_addr_q.size() && b < 3; b++) begin
      checks++; if (ar_addr_q[b] !== exp_addr[b]) begin errors++;
        $display("FAIL bp_araddr%0d got %h exp %h", b, ar_addr_q[b], exp_addr[b]); end
    end
  endtask

  task automatic test_rresp_err();
    bit ok;
    clear_logs();
    tready = 1'b1;
    slave_err_beat = 5;
    do_start(32'h3000_0000, 16'd2);
    wait_done(800, ok);
    slave_err_beat = -1;
    checks++; if (!ok) begin errors++; $display("FAIL rresp_done_timeout got 0 exp 1"); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rresp_err_at_done got %b exp 1", err); end
    checks++; if (beat_q.size() != 32) begin errors++; $display("FAIL rresp_beat_count got %0d exp 32", beat_q.size()); end
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rresp_err_sticky got %b exp 1", err); end
    clear_logs();
    do_start(32'h3000_0000, 16'd1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rresp_err_cleared_on_start got %b exp 0", err); end
    wait_done(500, ok);
    checks++; if (!ok || err !== 1'b0) begin errors++; $display("FAIL rresp_clean_run done,err got %b%b exp 10", ok, err); end
  endtask

  task automatic test_short_rlast();
    bit ok;
    clear_logs();
    tready = 1'b1;
    slave_len = 8;
    do_start(32'h4000_0000, 16'd1);
    wait_done(500, ok);
    slave_len = 16;
    checks++; if (!ok) begin errors++; $display("FAIL short_done_timeout got 0 exp 1"); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL short_err got %b exp 1", err); end
    checks++; if (beat_q.size() != 8) begin errors++; $display("FAIL short_beat_count got %0d exp 8", beat_q.size()); end
    if (beat_q.size() >= 8) begin
      checks++; if (beat_q[7] !== {1'b1, 32'h4000_0000, 32'd7}) begin errors++;
        $display("FAIL short_last_beat got %h exp %h", beat_q[7], {1'b1, 32'h4000_0000, 32'd7}); end
    end
  endtask

  task automatic test_zero_bursts();
    int c0;
    clear_logs();
    c0 = done_cnt;
    @(negedge clk);
    start = 1'b1; base_addr = 32'h5000_0000; burst_num = 16'd0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy got %b exp 1", busy); end
    burst_num = 16'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (done_cnt - c0 != 1) begin errors++; $display("FAIL zero_done_pulses got %0d exp 1", done_cnt - c0); end
    checks++; if (done_busy !== 1'b1) begin errors++; $display("FAIL zero_busy_at_done got %b exp 1", done_busy); end
    checks++; if (ar_addr_q.size() != 0) begin errors++; $display("FAIL zero_no_ar got %0d exp 0", ar_addr_q.size()); end
    checks++; if ({busy, tvalid} !== 2'b00) begin errors++; $display("FAIL zero_idle busy,tvalid got %b exp 00", {busy, tvalid}); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    tready = 1'b0;
    do_start(32'h6000_0000, 16'd2);
    for (int i = 0; i < 200 && ar_addr_q.size() < 1; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({arvalid, rready, tvalid, tlast, busy, done, err} !== 7'b0) begin errors++;
      $display("FAIL midrst_ctrl got %b exp 0000000", {arvalid, rready, tvalid, tlast, busy, done, err}); end
    checks++; if ({araddr, arlen, arsize, arburst, arcache} !== 49'h0) begin errors++;
      $display("FAIL midrst_ar got %h exp 0", {araddr, arlen, arsize, arburst, arcache}); end
    checks++; if (tdata !== 64'h0) begin errors++; $display("FAIL midrst_tdata got %h exp 0", tdata); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_logs();
    tready = 1'b1;
    do_start(32'h7000_0000, 16'd1);
    wait_done(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_done_timeout got 0 exp 1"); end
    checks++; if (ar_addr_q.size() != 1 || ar_addr_q[0] !== 32'h7000_0000) begin errors++;
      $display("FAIL midrst_ar_after count %0d exp 1 addr exp 70000000", ar_addr_q.size()); end
    checks++; if (beat_q.size() != 16) begin errors++; $display("FAIL midrst_beat_count got %0d exp 16", beat_q.size()); end
    for (int i = 0; i < beat_q.size() && i < 16; i++) begin
      checks++; if (beat_q[i] !== {(i == 15), 32'h7000_0000, 32'(i)}) begin errors++;
        $display("FAIL midrst_beat%0d got %h exp %h", i, beat_q[i], {(i == 15), 32'h7000_0000, 32'(i)}); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err got %b exp 0", err); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; burst_num = '0; tready = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_rresp_err();
    test_short_rlast();
    test_zero_bursts();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
